// File: rtl/ifmap_pkg.sv
// Shared constants and FSM state type for the ifmap replay controller.
package ifmap_pkg;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READ,
    FLUSH
  } state_t;
endpackage

// File: rtl/ifmap_ctrl_if.sv
// Bundle of job control, input stream, buffer port and output stream signals.
interface ifmap_ctrl_if #(
  parameter int unsigned ADDR_W = ifmap_pkg::ADDR_W,
  parameter int unsigned DATA_W = ifmap_pkg::DATA_W
);
  logic              start_i;
  logic [7:0]        len_i;
  logic [7:0]        repeat_i;
  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ready_o;
  logic              buf_wren_o;
  logic              buf_rden_o;
  logic [ADDR_W-1:0] buf_addr_o;
  logic [DATA_W-1:0] buf_wdata_o;
  logic [DATA_W-1:0] buf_rdata_i;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic [7:0]        m_pass_o;
  logic              busy_o;
  logic              done_o;

  // Controller side.
  modport master (
    input  start_i, len_i, repeat_i, s_valid_i, s_data_i, buf_rdata_i,
    output s_ready_o, buf_wren_o, buf_rden_o, buf_addr_o, buf_wdata_o,
           m_valid_o, m_data_o, m_last_o, m_pass_o, busy_o, done_o
  );

  // Environment side: job source, stream producer/consumer and buffer.
  modport slave (
    output start_i, len_i, repeat_i, s_valid_i, s_data_i, buf_rdata_i,
    input  s_ready_o, buf_wren_o, buf_rden_o, buf_addr_o, buf_wdata_o,
           m_valid_o, m_data_o, m_last_o, m_pass_o, busy_o, done_o
  );
endinterface

// File: rtl/ifmap_ctrl.sv
// Fills an external buffer with one ifmap vector, then replays it repeat_i times
// as a gap-free output stream tagged with pass index and end-of-pass marker.
module ifmap_ctrl #(
  parameter int unsigned DEPTH  = ifmap_pkg::DEPTH,
  parameter int unsigned ADDR_W = ifmap_pkg::ADDR_W,
  parameter int unsigned DATA_W = ifmap_pkg::DATA_W
) (
  input logic          clk,
  input logic          rst,
  ifmap_ctrl_if.master bus
);
  import ifmap_pkg::*;

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  len_q, len_m1, wcnt, rcnt;
  logic [7:0]        rep_q, pass_q, m_pass_q;
  logic              m_valid_q, m_last_q;
  logic              len_ok, start_ok, wr_hs, wr_last, rd_en, rd_last, pass_last;
  logic [DATA_W-1:0] m_data;

  always_comb begin
    len_ok    = (bus.len_i != '0) && ({1'b0, bus.len_i} <= 9'(DEPTH));
    start_ok  = (state == IDLE) && bus.start_i && len_ok && (bus.repeat_i != '0);
    len_m1    = len_q - CNT_W'(1);
    wr_hs     = (state == FILL) && bus.s_valid_i;
    wr_last   = (wcnt == len_m1);
    rd_en     = (state == READ);
    rd_last   = (rcnt == len_m1);
    pass_last = (pass_q == rep_q - 8'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_ok) state_nx = FILL;
      FILL:  if (wr_hs && wr_last) state_nx = READ;
      READ:  if (rd_last && pass_last) state_nx = FLUSH;
      FLUSH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      rep_q     <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      pass_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_pass_q  <= '0;
    end else begin
      if (start_ok) begin
        len_q  <= CNT_W'(bus.len_i);
        rep_q  <= bus.repeat_i;
        wcnt   <= '0;
        rcnt   <= '0;
        pass_q <= '0;
      end
      if (wr_hs) wcnt <= wcnt + CNT_W'(1);
      if (rd_en) begin
        if (rd_last) begin
          rcnt   <= '0;
          pass_q <= pass_q + 8'd1;
        end else begin
          rcnt <= rcnt + CNT_W'(1);
        end
      end
      // Tag travels with the read so it lines up with buffer read data.
      m_valid_q <= rd_en;
      m_last_q  <= rd_en && rd_last;
      m_pass_q  <= rd_en ? pass_q : '0;
    end
  end

  always_comb begin
    m_data          = m_valid_q ? bus.buf_rdata_i : '0;
    bus.s_ready_o   = (state == FILL);
    bus.buf_wren_o  = wr_hs;
    bus.buf_rden_o  = rd_en;
    bus.buf_addr_o  = '0;
    if (wr_hs)      bus.buf_addr_o = wcnt[ADDR_W-1:0];
    else if (rd_en) bus.buf_addr_o = rcnt[ADDR_W-1:0];
    bus.buf_wdata_o = wr_hs ? bus.s_data_i : '0;
    bus.m_valid_o   = m_valid_q;
    bus.m_data_o    = m_data;
    bus.m_last_o    = m_last_q;
    bus.m_pass_o    = m_pass_q;
    bus.busy_o      = (state != IDLE);
    bus.done_o      = (state == FLUSH);
  end
endmodule

// File: tb/tb_ifmap_ctrl.sv
// Directed bench for ifmap_ctrl with a behavioural 128x8 buffer beside it.
module tb_ifmap_ctrl;
  localparam int unsigned LOG = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifmap_ctrl_if bus ();
  ifmap_ctrl #(.DEPTH(128), .ADDR_W(7), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem [0:127];
  always @(posedge clk) begin
    if (bus.buf_wren_o) mem[bus.buf_addr_o] <= bus.buf_wdata_o;
    if (bus.buf_rden_o) bus.buf_rdata_i <= mem[bus.buf_addr_o];
  end

  int unsigned cyc = 0, n_wr = 0, n_rd = 0, n_out = 0, n_done = 0, n_coll = 0;
  int unsigned wr_addr [LOG], wr_data [LOG], wr_cyc [LOG], rd_addr [LOG];
  int unsigned out_data [LOG], out_last [LOG], out_pass [LOG], out_done [LOG], out_cyc [LOG];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.buf_wren_o && n_wr < LOG) begin
      wr_addr[n_wr] <= 32'(bus.buf_addr_o);
      wr_data[n_wr] <= 32'(bus.buf_wdata_o);
      wr_cyc[n_wr]  <= cyc;
      n_wr          <= n_wr + 1;
    end
    if (bus.buf_rden_o && n_rd < LOG) begin
      rd_addr[n_rd] <= 32'(bus.buf_addr_o);
      n_rd          <= n_rd + 1;
    end
    if (bus.m_valid_o && n_out < LOG) begin
      out_data[n_out] <= 32'(bus.m_data_o);
      out_last[n_out] <= 32'(bus.m_last_o);
      out_pass[n_out] <= 32'(bus.m_pass_o);
      out_done[n_out] <= 32'(bus.done_o);
      out_cyc[n_out]  <= cyc;
      n_out           <= n_out + 1;
    end
    if (bus.buf_wren_o && bus.buf_rden_o) n_coll <= n_coll + 1;
    if (bus.done_o) n_done <= n_done + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] jd [0:127];
  int unsigned b_wr, b_rd, b_out, b_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.s_ready_o, bus.buf_wren_o, bus.buf_rden_o, bus.buf_addr_o,
                bus.buf_wdata_o, bus.m_valid_o, bus.m_data_o, bus.m_last_o,
                bus.m_pass_o, bus.busy_o, bus.done_o});
  endfunction

  task automatic snapshot();
    b_wr = n_wr; b_rd = n_rd; b_out = n_out; b_done = n_done;
  endtask

  task automatic start_job(input int unsigned l, input int unsigned r);
    bus.start_i = 1'b1; bus.len_i = 8'(l); bus.repeat_i = 8'(r);
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic feed(input int unsigned l, input int unsigned gap);
    for (int unsigned i = 0; i < l; i++) begin
      bus.s_valid_i = 1'b1; bus.s_data_i = jd[i];
      tick();
      bus.s_valid_i = 1'b0;
      if (i + 1 < l) for (int unsigned g = 0; g < gap; g++) tick();
    end
  endtask

  // Expected stream: element k is jd[k mod l] of pass k/l; done only on the final one.
  task automatic run_job(input string tag, input int unsigned l, input int unsigned r,
                         input int unsigned gap, input bit poke);
    int unsigned n;
    n = l * r;
    snapshot();
    start_job(l, r);
    chk({tag, "_busy_start"}, 64'(bus.busy_o), 64'(1));
    chk({tag, "_ready_fill"}, 64'(bus.s_ready_o), 64'(1));
    feed(l, gap);
    if (poke) begin
      bus.start_i = 1'b1; bus.len_i = 8'd1; bus.repeat_i = 8'd1;
      tick(); tick();
      bus.start_i = 1'b0;
      chk({tag, "_busy_poke"}, 64'(bus.busy_o), 64'(1));
    end
    for (int unsigned c = 0; c < 600 && n_done == b_done; c++) tick();
    chk({tag, "_done_cnt"}, 64'(n_done - b_done), 64'(1));
    tick();
    chk({tag, "_idle_after"}, 64'(bus.busy_o), 64'(0));
    chk({tag, "_n_wr"}, 64'(n_wr - b_wr), 64'(l));
    for (int unsigned i = 0; i < l; i++) begin
      chk($sformatf("%s_wr_addr[%0d]", tag, i), 64'(wr_addr[b_wr + i]), 64'(i));
      chk($sformatf("%s_wr_data[%0d]", tag, i), 64'(wr_data[b_wr + i]), 64'(jd[i]));
    end
    chk({tag, "_n_rd"}, 64'(n_rd - b_rd), 64'(n));
    chk({tag, "_n_out"}, 64'(n_out - b_out), 64'(n));
    chk({tag, "_latency"}, 64'(out_cyc[b_out] - wr_cyc[b_wr + l - 1]), 64'(2));
    for (int unsigned k = 0; k < n; k++) begin
      chk($sformatf("%s_rd_addr[%0d]", tag, k), 64'(rd_addr[b_rd + k]), 64'(k % l));
      chk($sformatf("%s_data[%0d]", tag, k), 64'(out_data[b_out + k]), 64'(jd[k % l]));
      chk($sformatf("%s_last[%0d]", tag, k), 64'(out_last[b_out + k]), 64'((k % l) == l - 1));
      chk($sformatf("%s_pass[%0d]", tag, k), 64'(out_pass[b_out + k]), 64'(k / l));
      chk($sformatf("%s_done[%0d]", tag, k), 64'(out_done[b_out + k]), 64'(k == n - 1));
      chk($sformatf("%s_gap[%0d]", tag, k), 64'(out_cyc[b_out + k] - out_cyc[b_out]), 64'(k));
    end
    chk({tag, "_wr_rd_overlap"}, 64'(n_coll), 64'(0));
  endtask

  task automatic illegal(input string tag, input int unsigned l, input int unsigned r);
    start_job(l, r);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'(0));
    chk({tag, "_ready"}, 64'(bus.s_ready_o), 64'(0));
    tick();
  endtask

  initial begin
    bit seen;
    bus.start_i = 1'b0; bus.len_i = '0; bus.repeat_i = '0;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0;

    tick(); tick(); tick();
    chk("rst_outs", outs(), 64'(0));
    chk("rst_busy", 64'(bus.busy_o), 64'(0));

    // Start accepted on the very first edge after reset release.
    rst = 1'b0;
    jd[0] = 8'h11; jd[1] = 8'h22; jd[2] = 8'h33; jd[3] = 8'h44;
    run_job("basic", 4, 2, 0, 1'b0);

    jd[0] = 8'hA1; jd[1] = 8'hB2; jd[2] = 8'hC3;
    run_job("gaps", 3, 1, 2, 1'b0);

    for (int unsigned i = 0; i < 128; i++) jd[i] = 8'(i);
    run_job("full", 128, 1, 0, 1'b0);

    illegal("ill_len0", 0, 1);
    illegal("ill_rep0", 5, 0);
    illegal("ill_len129", 129, 1);

    jd[0] = 8'h0F; jd[1] = 8'hF0; jd[2] = 8'h3C; jd[3] = 8'hC3;
    run_job("poke", 4, 2, 0, 1'b1);

    // Reset during the second pass of a len=5 repeat=3 job.
    for (int unsigned i = 0; i < 5; i++) jd[i] = 8'(8'h50 + i);
    snapshot();
    start_job(5, 3);
    feed(5, 0);
    seen = 1'b0;
    for (int unsigned c = 0; c < 100 && !seen; c++) begin
      if (n_out > b_out && out_pass[n_out - 1] == 1) seen = 1'b1;
      else tick();
    end
    chk("mid_pass1_seen", 64'(seen), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", outs(), 64'(0));
    tick(); tick();
    chk("mid_rst_outs_held", outs(), 64'(0));
    rst = 1'b0;
    chk("mid_rst_no_done", 64'(n_done - b_done), 64'(0));
    jd[0] = 8'h5A; jd[1] = 8'hA5;
    run_job("after_rst", 2, 1, 0, 1'b0);

    jd[0] = 8'h7E;
    run_job("min", 1, 3, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifmap_ctrl.md
IFMAP_CTRL -- requirements
Module: ifmap_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- DEPTH, 128, buffer entries.
- ADDR_W, 7, log2(DEPTH).
- DATA_W, 8, ifmap element width.
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  begin job (sampled in IDLE)
- len_i  in  8  elements per vector, 1..DEPTH
- repeat_i  in  8  replay passes, 1..255
- s_valid_i  in  1  input element valid
- s_data_i  in  DATA_W  input element
- s_ready_o  out  1  controller accepts element
- buf_wren_o  out  1  buffer write enable
- buf_rden_o  out  1  buffer read enable
- buf_addr_o  out  ADDR_W  buffer address
- buf_wdata_o  out  DATA_W  buffer write data
- buf_rdata_i  in  DATA_W  buffer read data, valid 1 cycle after buf_rden_o
- m_valid_o  out  1  output element valid, no backpressure
- m_data_o  out  DATA_W  output element
- m_last_o  out  1  last element of a pass
- m_pass_o  out  8  index of the current pass
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse

Function
REQ-004 FSM states: IDLE, FILL, READ, FLUSH.
REQ-005 IDLE:
- start_i=1 with len_i in 1..DEPTH and repeat_i≠0 latches len and rep, clears counters, and goes to FILL.
- Any other start_i value is ignored.
REQ-006 FILL:
- s_ready_o=1.
- On each s_valid_i&&s_ready_o: buf_wren_o=1, buf_addr_o=wcnt, buf_wdata_o=s_data_i, then wcnt increments.
- The handshake with wcnt=len-1 moves the FSM to READ.
REQ-007 Outside FILL: s_ready_o=0 and buf_wren_o=0.
REQ-008 READ, every cycle:
- buf_rden_o=1, buf_addr_o=rcnt.
- rcnt wraps to 0 after len-1 and increments the pass counter.
- Issuing rcnt=len-1 in pass rep-1 moves the FSM to FLUSH.
REQ-009 Output timing:
- m_valid_o is buf_rden_o delayed one register; m_data_o=buf_rdata_i.
- m_last_o and m_pass_o are the registered tag of the issued read; m_last_o is high for the element issued at rcnt=len-1.
REQ-010 FLUSH lasts 1 cycle:
- Emits the final output element, with done_o=1 in the same cycle, then returns to IDLE.
REQ-011 busy_o=1 in FILL, READ and FLUSH.
REQ-012 Latency and throughput:
- First m_valid_o occurs 2 cycles after the final write handshake.
- Output rate is 1 element per cycle, with no gaps between passes.
- A job emits exactly len*rep elements.
REQ-013 start_i is ignored while busy_o=1.
REQ-014 Write and read never occur in the same cycle.
REQ-015 buf_addr_o never exceeds len-1.
REQ-016 len=1: every output element has m_last_o=1.
REQ-017 len=DEPTH: addresses 0..127 are used and the 7-bit counters wrap correctly; counters are ADDR_W+1 wide internally.

Reset
REQ-018 Reset mid-operation aborts the job immediately, with no done_o.
REQ-019 While rst=1, the state is IDLE and all counters, latched len/rep and pipeline registers are 0.
REQ-020 While rst=1, every output is 0, including s_ready_o, buf_*_o, m_*_o, busy_o and done_o.
REQ-021 The first start_i is accepted on the first clk edge after rst deasserts.

Structure
REQ-022 Shared package ifmap_pkg holds:
- DEPTH, ADDR_W, DATA_W.
- The FSM state enum type.
REQ-023 No sub-module; the 128x8 single-port buffer is instantiated by the parent, beside this controller.

Verification
REQ-024 Basic job: len=4, repeat=2, data 0x11,0x22,0x33,0x44 -> output 0x11..0x44 twice; m_last on the 4th and 8th elements; m_pass 0 then 1; done_o with the 8th element.
REQ-025 Input gaps: len=3 with s_valid low 2 cycles between elements -> writes to addresses 0,1,2 only; first m_valid 2 cycles after the 3rd handshake.
REQ-026 Full depth: len=128, repeat=1, ramp data 0..127 -> output 0..127, addresses 0..127, single m_last on the element 127.
REQ-027 Illegal starts: start with len=0 or repeat=0 -> stays IDLE, busy_o=0; start during READ ignored, output unchanged.
REQ-028 Mid-job reset: rst pulse during pass 1 of len=5, repeat=3 -> all outputs 0 within the reset cycle, no done_o; a new job len=2, repeat=1 then completes correctly.
REQ-029 Minimum job: len=1, repeat=3 -> 3 identical consecutive outputs, each with m_last=1, done_o with the 3rd.
